// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial little-endian load/store engine between the mem stage and an 8-bit RAM.
// Build option MEM_CTRL_RDY_EN adds an rdy_i input that freezes the access while low.
module mem_ctrl #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              sext_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              done_o,
  output logic              stall_req_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic              ram_we_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i
`ifdef MEM_CTRL_RDY_EN
  ,
  input  logic              rdy_i
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  logic rdy;
`ifdef MEM_CTRL_RDY_EN
  assign rdy = rdy_i;
`else
  assign rdy = 1'b1;
`endif

  state_t              state_q, state_d;
  logic [1:0]          k_q, k_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                sext_q, sext_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rbuf_q, rbuf_d;
  logic                cap_vld_q, cap_vld_d;
  logic [1:0]          cap_lane_q, cap_lane_d;
  logic [ADDR_W-1:0]   ram_a_q, ram_a_d;
  logic                ram_we_q, ram_we_d;
  logic [7:0]          ram_dout_q, ram_dout_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                done_q, done_d;

  logic [1:0]          k_inc;
  logic [1:0]          k_last;
  logic [31:0]         load_word;

  function automatic logic [1:0] last_idx(input logic [1:0] size);
    case (size)
      2'd0:    return 2'd0;
      2'd1:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] size,
                                         input logic sext);
    case (size)
      2'd0:    return {{24{sext & v[7]}}, v[7:0]};
      2'd1:    return {{16{sext & v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  assign k_inc  = k_q + 2'd1;
  assign k_last = last_idx(size_q);

  // The read buffer tracks whatever byte the pins showed last cycle, independent of rdy,
  // so a frozen address simply re-captures the same lane and the final word stays correct.
  always_comb begin
    load_word = rbuf_q;
    if (cap_vld_q) begin
      load_word[{cap_lane_q, 3'b000} +: 8] = ram_din_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    we_d       = we_q;
    size_d     = size_q;
    sext_d     = sext_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rbuf_d     = load_word;
    cap_vld_d  = !we_q && (state_q == ST_XFER || state_q == ST_WAIT);
    cap_lane_d = k_q;
    ram_a_d    = ram_a_q;
    ram_we_d   = ram_we_q;
    ram_dout_d = ram_dout_q;
    rdata_d    = rdata_q;
    done_d     = done_q;

    if (rdy) begin
      done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            we_d       = we_i;
            size_d     = size_i;
            sext_d     = sext_i;
            addr_d     = addr_i[ADDR_W-1:0];
            wdata_d    = we_i ? wdata_i : 32'h0;
            k_d        = 2'd0;
            ram_a_d    = addr_i[ADDR_W-1:0];
            ram_we_d   = we_i;
            ram_dout_d = we_i ? wdata_i[7:0] : 8'h00;
            state_d    = ST_XFER;
          end
        end
        ST_XFER: begin
          if (k_q != k_last) begin
            k_d        = k_inc;
            ram_a_d    = addr_q + ADDR_W'(k_inc);
            ram_dout_d = byte_of(wdata_q, k_inc);
          end else begin
            ram_we_d = 1'b0;
            if (we_q) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          rdata_d = extend(load_word, size_q, sext_q);
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
        ST_DONE: begin
          // Upstream still presents the finished request here, so it must not be re-accepted.
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      k_q        <= 2'd0;
      we_q       <= 1'b0;
      size_q     <= 2'd0;
      sext_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      rbuf_q     <= 32'h0;
      cap_vld_q  <= 1'b0;
      cap_lane_q <= 2'd0;
      ram_a_q    <= '0;
      ram_we_q   <= 1'b0;
      ram_dout_q <= 8'h00;
      rdata_q    <= 32'h0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      we_q       <= we_d;
      size_q     <= size_d;
      sext_q     <= sext_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
      cap_vld_q  <= cap_vld_d;
      cap_lane_q <= cap_lane_d;
      ram_a_q    <= ram_a_d;
      ram_we_q   <= ram_we_d;
      ram_dout_q <= ram_dout_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
    end
  end

  assign rdata_o     = rdata_q;
  assign done_o      = done_q & rdy;
  assign ram_a_o     = ram_a_q;
  assign ram_we_o    = ram_we_q & rdy;
  assign ram_dout_o  = ram_dout_q;
  assign stall_req_o = (state_q == ST_IDLE && req_i) || state_q == ST_XFER || state_q == ST_WAIT;

  generate
    if (ADDR_W < 32) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr_i[31:ADDR_W];
    end
  endgenerate

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: table vectors, reset/abort sequences and random traffic against a byte-array model.
// Models an 8-bit RAM with one-cycle read latency behind the controller.
module tb_mem_ctrl;
  localparam int ADDR_W   = 17;
  localparam int MEM_SIZE = 1 << ADDR_W;
  localparam bit [31:0] AMASK = MEM_SIZE - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_i, we_i, sext_i;
  logic [1:0]        size_i;
  logic [31:0]       addr_i, wdata_i;
  logic [31:0]       rdata_o;
  logic              done_o, stall_req_o, ram_we_o;
  logic [ADDR_W-1:0] ram_a_o;
  logic [7:0]        ram_dout_o;
  logic [7:0]        ram_din_i = 8'h00;
`ifdef MEM_CTRL_RDY_EN
  logic              rdy_i = 1'b1;
`endif

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .size_i(size_i), .sext_i(sext_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .done_o(done_o),
    .stall_req_o(stall_req_o), .ram_a_o(ram_a_o), .ram_we_o(ram_we_o),
    .ram_dout_o(ram_dout_o), .ram_din_i(ram_din_i)
`ifdef MEM_CTRL_RDY_EN
    , .rdy_i(rdy_i)
`endif
  );

  // Physical RAM (fed by the DUT pins) and an independent reference image.
  bit [7:0]          ram     [0:MEM_SIZE-1];
  bit [7:0]          ref_mem [0:MEM_SIZE-1];
  logic              poke_en = 1'b0;
  logic [ADDR_W-1:0] poke_a  = '0;
  logic [7:0]        poke_d  = 8'h00;

  always @(posedge clk) begin
    if (poke_en) ram[poke_a] <= poke_d;
    else if (ram_we_o) ram[ram_a_o] <= ram_dout_o;
    ram_din_i <= ram[ram_a_o];
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_rd = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input bit [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit [31:0] ref_load(input bit [31:0] addr, input bit [1:0] sz, input bit sx);
    bit [31:0] v = 0;
    int n = nbytes(sz);
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[(addr + i) & AMASK]) << (8 * i));
    if (sx && n == 1 && v >= 32'h80)   v = v | 32'hFFFF_FF00;
    if (sx && n == 2 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic ref_store(input bit [31:0] addr, input bit [1:0] sz, input bit [31:0] wd);
    for (int i = 0; i < nbytes(sz); i++) ref_mem[(addr + i) & AMASK] = 8'((wd >> (8 * i)) & 32'hFF);
  endtask

  task automatic poke(input bit [31:0] a, input bit [7:0] d);
    poke_a = a[ADDR_W-1:0]; poke_d = d; poke_en = 1'b1;
    @(negedge clk);
    poke_en = 1'b0;
    ref_mem[a & AMASK] = d;
  endtask

  // One full access: request driven in cycle T, every following cycle checked until done.
  task automatic access(input string tag, input bit we, input bit [1:0] sz, input bit sx,
                        input bit [31:0] addr, input bit [31:0] wd, input bit [31:0] exp_rd);
    int n   = nbytes(sz);
    int lat = we ? n + 1 : n + 2;
    int f0  = n_fail;
    @(negedge clk);
    req_i = 1'b1; we_i = we; size_i = sz; sext_i = sx; addr_i = addr; wdata_i = wd;
    #1 chk({tag, " stall@T"}, stall_req_o, 1);
    for (int j = 1; j <= lat; j++) begin
      @(negedge clk);
      #1;
      if (j <= n) begin
        chk($sformatf("%s ram_a@T+%0d", tag, j), ram_a_o, (addr + j - 1) & AMASK);
        chk($sformatf("%s ram_we@T+%0d", tag, j), ram_we_o, we);
        if (we) chk($sformatf("%s ram_dout@T+%0d", tag, j), ram_dout_o, (wd >> (8 * (j - 1))) & 32'hFF);
      end else begin
        chk($sformatf("%s ram_we@T+%0d", tag, j), ram_we_o, 0);
      end
      chk($sformatf("%s done@T+%0d", tag, j), done_o, (j == lat));
      chk($sformatf("%s stall@T+%0d", tag, j), stall_req_o, (j != lat));
    end
    chk({tag, " rdata"}, rdata_o, we ? last_rd : exp_rd);
    if (!we) last_rd = exp_rd;
    $display("txn %s we=%0d size=%0d sext=%0d addr=%08h wdata=%08h rdata=%08h %s", tag, we, sz, sx,
             addr, wd, rdata_o, (n_fail == f0) ? "ok" : "bad");
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    req_i = 1'b0;
    #1;
    chk("idle done", done_o, 0);
    chk("idle stall", stall_req_o, 0);
  endtask

  typedef struct {
    bit        we;
    bit [1:0]  sz;
    bit        sx;
    bit [31:0] addr;
    bit [31:0] wd;
    bit [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  initial begin
    bit [31:0] a, wd, e;
    bit        we, sx;
    bit [1:0]  sz;

    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'h1122_3344, 32'h0};
    vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0200, 32'h0,         32'hFFFF_FF80};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0200, 32'h0,         32'h0000_0080};
    vecs[3]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0201, 32'h0,         32'h0000_FFFE};
    vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h0001_FFFE, 32'h0,         32'hD4C3_B2A1};
    vecs[5]  = '{1'b0, 2'd2, 1'b1, 32'h0000_0100, 32'h0,         32'h1122_3344};
    vecs[6]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0,         32'h0000_0011};
    vecs[7]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0300, 32'hABCD_8001, 32'h0};
    vecs[8]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0300, 32'h0,         32'hFFFF_8001};
    vecs[9]  = '{1'b1, 2'd3, 1'b0, 32'h0001_FFFF, 32'h5566_7788, 32'h0};
    vecs[10] = '{1'b0, 2'd3, 1'b0, 32'h0001_FFFF, 32'h0,         32'h5566_7788};
    vecs[11] = '{1'b0, 2'd1, 1'b1, 32'h0001_FFFE, 32'h0,         32'hFFFF_88A1};
    vecs[12] = '{1'b0, 2'd0, 1'b1, 32'hFFFE_0002, 32'h0,         32'h0000_0055};

    rst = 1'b1; req_i = 1'b0; we_i = 1'b0; size_i = 2'd0; sext_i = 1'b0;
    addr_i = 32'h0; wdata_i = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    poke(32'h0000_0200, 8'h80);
    poke(32'h0000_0201, 8'hFE);
    poke(32'h0000_0202, 8'hFF);
    poke(32'h0001_FFFE, 8'hA1);
    poke(32'h0001_FFFF, 8'hB2);
    poke(32'h0000_0000, 8'hC3);
    poke(32'h0000_0001, 8'hD4);

    // Reset state.
    #1;
    chk("rst ram_a", ram_a_o, 0);
    chk("rst ram_we", ram_we_o, 0);
    chk("rst ram_dout", ram_dout_o, 0);
    chk("rst rdata", rdata_o, 0);
    chk("rst done", done_o, 0);
    chk("rst stall req0", stall_req_o, 0);
    req_i = 1'b1;
    #1 chk("rst stall req1", stall_req_o, 1);
    @(negedge clk);
    rst = 1'b0; req_i = 1'b0;
    #1 chk("post-rst done", done_o, 0);

    // Table vectors; alternate back-to-back and gapped requests.
    for (int i = 0; i < 13; i++) begin
      access($sformatf("vec%0d", i), vecs[i].we, vecs[i].sz, vecs[i].sx, vecs[i].addr,
             vecs[i].wd, vecs[i].exp);
      if (vecs[i].we) ref_store(vecs[i].addr, vecs[i].sz, vecs[i].wd);
      if (i % 2 == 1) idle_cycle();
    end
    idle_cycle();

    // Reset in cycle T+2 of a word store: bytes 0 and 1 land, nothing else happens.
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; size_i = 2'd2; sext_i = 1'b0;
    addr_i = 32'h0000_0400; wdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    #1 chk("abort ram_we@T+1", ram_we_o, 1);
    @(negedge clk);
    #1 chk("abort ram_a@T+2", ram_a_o, 32'h401);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("abort ram_we@T+3", ram_we_o, 0);
    chk("abort ram_a@T+3", ram_a_o, 0);
    chk("abort ram_dout@T+3", ram_dout_o, 0);
    chk("abort done@T+3", done_o, 0);
    chk("abort rdata@T+3", rdata_o, 0);
    chk("abort stall=req@T+3", stall_req_o, 1);
    rst = 1'b0; req_i = 1'b0;
    #1 chk("abort stall=req0", stall_req_o, 0);
    @(negedge clk);
    #1 chk("abort done@T+4", done_o, 0);
    last_rd = 32'h0;
    ref_mem[32'h400] = 8'hEF;
    ref_mem[32'h401] = 8'hBE;
    $display("txn abort store addr=00000400 reset at T+2");
    access("after-abort", 1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'h0, 32'h0000_BEEF);
    idle_cycle();

`ifdef MEM_CTRL_RDY_EN
    // Word load with rdy_i low for T+2..T+4: pins freeze, completion slips to T+9.
    begin
      bit [31:0] exp_a;
      @(negedge clk);
      req_i = 1'b1; we_i = 1'b0; size_i = 2'd2; sext_i = 1'b0; addr_i = 32'h0000_0100;
      #1 chk("rdy stall@T", stall_req_o, 1);
      for (int j = 1; j <= 9; j++) begin
        @(negedge clk);
        rdy_i = (j >= 2 && j <= 4) ? 1'b0 : 1'b1;
        #1;
        exp_a = (j == 1) ? 32'h100 : (j <= 5) ? 32'h101 : (j == 6) ? 32'h102 : 32'h103;
        chk($sformatf("rdy ram_a@T+%0d", j), ram_a_o, exp_a);
        chk($sformatf("rdy ram_we@T+%0d", j), ram_we_o, 0);
        chk($sformatf("rdy done@T+%0d", j), done_o, (j == 9));
        chk($sformatf("rdy stall@T+%0d", j), stall_req_o, (j != 9));
      end
      chk("rdy rdata", rdata_o, 32'h1122_3344);
      last_rd = 32'h1122_3344;
      $display("txn rdy-hold load word addr=00000100 rdata=%08h", rdata_o);
      idle_cycle();
    end
`endif

    // Random traffic against the reference image, clustered so loads hit earlier stores.
    for (int i = 0; i < 150; i++) begin
      a  = ($urandom_range(0, 1) ? 32'h0000_0500 : 32'h0001_FFE0) + $urandom_range(0, 63);
      a  = a ^ ($urandom & 32'hFFFC_0000);
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sx = 1'($urandom_range(0, 1));
      wd = $urandom;
      e  = we ? 32'h0 : ref_load(a, sz, sx);
      access($sformatf("rnd%0d", i), we, sz, sx, a, wd, e);
      if (we) ref_store(a, sz, wd);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
